// File: rtl/test_sequencer_if.sv
// Handshake bundle between the test sequencer (slave side) and the test
// channels/controller that start runs and report completion (master side).
interface test_sequencer_if #(
  parameter int N_TESTS = 8
);
  localparam int IW = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

  logic               start;
  logic [N_TESTS-1:0] test_mask;
  logic               done;
  logic [N_TESTS-1:0] fails;
  logic [N_TESTS-1:0] en;
  logic               busy;
  logic               finished;
  logic               pass;
  logic [N_TESTS-1:0] fail_mask;
  logic [N_TESTS-1:0] timeout_mask;
  logic               aborted;
  logic [IW-1:0]      cur_index;

  modport master (
    output start, test_mask, done, fails,
    input  en, busy, finished, pass, fail_mask, timeout_mask, aborted, cur_index
  );

  modport slave (
    input  start, test_mask, done, fails,
    output en, busy, finished, pass, fail_mask, timeout_mask, aborted, cur_index
  );
endinterface

// File: rtl/test_sequencer.sv
// Runs selected test channels one at a time, lowest index first, collecting
// per-test failures. Define TEST_SEQUENCER_WATCHDOG_EN to add the watchdog.
module test_sequencer #(
  parameter int N_TESTS = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  test_sequencer_if.slave bus
);
  localparam int IW = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [N_TESTS-1:0] en_q, en_d;
  logic [N_TESTS-1:0] pend_q, pend_d;
  logic [N_TESTS-1:0] fmask_q, fmask_d;
  logic [IW-1:0]      idx_q, idx_d, low_idx;
  logic               busy_q, busy_d;
  logic               fin_q, fin_d;
  logic               pass_q, pass_d;
  logic               abort_d;

`ifdef TEST_SEQUENCER_WATCHDOG_EN
  localparam int             WW      = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0]  WD_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0]      wdog_q, wdog_d;
  logic [N_TESTS-1:0] tmo_q, tmo_d;
  logic               abort_q;
`endif

  always_comb begin
    low_idx = '0;
    for (int i = N_TESTS - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = IW'(i);
    end
  end

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    pend_d  = pend_q;
    fmask_d = fmask_q;
    idx_d   = idx_q;
`ifdef TEST_SEQUENCER_WATCHDOG_EN
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
    abort_d = abort_q;
`else
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE, FINISH: begin
        if (bus.start) begin
          pend_d  = bus.test_mask;
          fmask_d = '0;
          state_d = SCAN;
`ifdef TEST_SEQUENCER_WATCHDOG_EN
          tmo_d   = '0;
          abort_d = 1'b0;
          wdog_d  = '0;
`endif
        end
      end
      SCAN: begin
        if (pend_q == '0) begin
          state_d = FINISH;
        end else if (!bus.done) begin
          idx_d   = low_idx;
          en_d    = N_TESTS'(1) << low_idx;
          state_d = RUN;
`ifdef TEST_SEQUENCER_WATCHDOG_EN
          wdog_d  = '0;
        end else if (wdog_q == WD_LAST) begin
          // done never released: give up on the rest of the run
          abort_d = 1'b1;
          state_d = FINISH;
        end else begin
          wdog_d  = wdog_q + WW'(1);
`endif
        end
      end
      RUN: begin
        if (bus.done) begin
          fmask_d[idx_q] = bus.fails[idx_q];
          pend_d[idx_q]  = 1'b0;
          en_d           = '0;
          state_d        = SCAN;
`ifdef TEST_SEQUENCER_WATCHDOG_EN
          wdog_d         = '0;
        end else if (wdog_q == WD_LAST) begin
          fmask_d[idx_q] = 1'b1;
          tmo_d[idx_q]   = 1'b1;
          pend_d[idx_q]  = 1'b0;
          en_d           = '0;
          state_d        = SCAN;
          wdog_d         = '0;
        end else begin
          wdog_d         = wdog_q + WW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SCAN) || (state_d == RUN);
    fin_d  = (state_d == FINISH);
    pass_d = fin_d && (fmask_d == '0) && !abort_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= '0;
      pend_q  <= '0;
      fmask_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      pass_q  <= 1'b0;
`ifdef TEST_SEQUENCER_WATCHDOG_EN
      wdog_q  <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      fmask_q <= fmask_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      pass_q  <= pass_d;
`ifdef TEST_SEQUENCER_WATCHDOG_EN
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
`endif
    end
  end

  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.finished  = fin_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fmask_q;
  assign bus.cur_index = idx_q;
`ifdef TEST_SEQUENCER_WATCHDOG_EN
  assign bus.timeout_mask = tmo_q;
  assign bus.aborted      = abort_q;
`else
  assign bus.timeout_mask = '0;
  assign bus.aborted      = 1'b0;
`endif
endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: expected enable order is queued at
// start and popped as each enable rises; a responder models the test channels.
module tb_test_sequencer;
  localparam int N   = 8;
  localparam int TMO = 16;
  localparam int DLY = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  test_sequencer_if #(.N_TESTS(N)) bus ();

  test_sequencer #(.N_TESTS(N), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int en_len[N];
  int cyc           = 0;
  int last_fall_cyc = 0;
  int stuck_idx     = -1;
  int fin_cyc;

  logic         force_done = 1'b0;
  logic         resp_done  = 1'b0;
  logic         stuck      = 1'b0;
  logic [N-1:0] fail_cfg   = '0;
  logic [N-1:0] hang_mask  = '0;

  assign bus.done = force_done | resp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i]) exp_q.push_back(i);
    bus.test_mask = mask;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_finished(input string tag, output int fc);
    int n;
    n = 0;
    while (bus.finished !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.finished, 1);
    fc = cyc;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_en"},    bus.en, 0);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_fin"},   bus.finished, 0);
    check({tag, "_pass"},  bus.pass, 0);
    check({tag, "_fmask"}, bus.fail_mask, 0);
    check({tag, "_tmask"}, bus.timeout_mask, 0);
    check({tag, "_abort"}, bus.aborted, 0);
    check({tag, "_idx"},   bus.cur_index, 0);
  endtask

  // Test-channel model: done rises DLY cycles after en, drops once en clears.
  initial begin : responder
    int cnt, idx;
    cnt = 0;
    bus.fails = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.en != '0) begin
        idx = onehot_idx(bus.en);
        cnt++;
        if (cnt == DLY && !hang_mask[idx]) begin
          resp_done = 1'b1;
          bus.fails = fail_cfg;
          if (idx == stuck_idx) stuck = 1'b1;
        end
      end else begin
        cnt = 0;
        if (!stuck) begin
          resp_done = 1'b0;
          bus.fails = '0;
        end
      end
    end
  end

  initial begin : monitor
    logic [N-1:0] prev;
    int len, e;
    prev = '0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (bus.en != '0) begin
        len++;
        if (prev == '0) begin
          if (exp_q.size() == 0) begin
            check("en_unexpected", bus.en, 0);
          end else begin
            e = exp_q.pop_front();
            check("en_order", bus.en, N'(1) << e);
          end
        end else if (bus.en != prev) begin
          check("en_gap", bus.en, prev);
        end
      end else if (prev != '0) begin
        en_len[onehot_idx(prev)] = len;
        last_fall_cyc = cyc;
        len = 0;
      end
      prev = bus.en;
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int n;
    bus.start     = 1'b0;
    bus.test_mask = '0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();

    // all eight tests pass
    fail_cfg = '0;
    do_start(8'hFF);
    wait_finished("all_fin", fin_cyc);
    check("all_pass",  bus.pass, 1);
    check("all_fmask", bus.fail_mask, 0);
    check("all_busy",  bus.busy, 0);
    check("all_seen",  exp_q.size(), 0);
    check("all_enlen", en_len[7], DLY);

    // sparse mask, test 2 fails; bits of inactive tests are also driven high
    fail_cfg = 8'h0E;
    do_start(8'hA5);
    wait_finished("sp_fin", fin_cyc);
    check("sp_fmask", bus.fail_mask, 8'h04);
    check("sp_pass",  bus.pass, 0);
    check("sp_seen",  exp_q.size(), 0);
    check("sp_idx",   bus.cur_index, 7);
    repeat (5) tick();
    check("hold_fin",   bus.finished, 1);
    check("hold_fmask", bus.fail_mask, 8'h04);
    fail_cfg = '0;

    // empty mask: one SCAN cycle then FINISH with pass
    do_start(8'h00);
    check("m0_busy", bus.busy, 1);
    check("m0_fin0", bus.finished, 0);
    tick();
    check("m0_fin",  bus.finished, 1);
    check("m0_pass", bus.pass, 1);

    // done held high at start: no enable until it drops
    force_done = 1'b1;
    do_start(8'h03);
    repeat (4) begin
      check("dh_en0", bus.en, 0);
      tick();
    end
    force_done = 1'b0;
    tick();
    check("dh_en1", bus.en, 8'h01);
    wait_finished("dh_fin", fin_cyc);
    check("dh_pass", bus.pass, 1);
    check("dh_seen", exp_q.size(), 0);

    // reset in the middle of test 4
    do_start(8'hFF);
    n = 0;
    while (bus.en !== 8'h10 && n < 500) begin
      tick();
      n++;
    end
    check("mr_en4", bus.en, 8'h10);
    tick();
    rst = 1'b1;
    tick();
    check_reset("mr");
    exp_q.delete();
    rst = 1'b0;
    tick();
    do_start(8'h03);
    wait_finished("mr_fin", fin_cyc);
    check("mr_pass", bus.pass, 1);
    check("mr_seen", exp_q.size(), 0);

`ifdef TEST_SEQUENCER_WATCHDOG_EN
    // test 3 never completes: watchdog retires it after TMO cycles
    hang_mask = 8'h08;
    do_start(8'hFF);
    wait_finished("wd_fin", fin_cyc);
    check("wd_enlen", en_len[3], TMO);
    check("wd_tmask", bus.timeout_mask, 8'h08);
    check("wd_fmask", bus.fail_mask, 8'h08);
    check("wd_pass",  bus.pass, 0);
    check("wd_abort", bus.aborted, 0);
    check("wd_seen",  exp_q.size(), 0);
    hang_mask = '0;

    // done stuck high after test 1: run aborts after TMO SCAN cycles
    stuck_idx = 1;
    do_start(8'hFF);
    wait_finished("ab_fin", fin_cyc);
    check("ab_abort", bus.aborted, 1);
    check("ab_pass",  bus.pass, 0);
    check("ab_left",  exp_q.size(), 6);
    check("ab_cycles", fin_cyc - last_fall_cyc, TMO);
    exp_q.delete();
    stuck_idx = -1;
    stuck     = 1'b0;
    repeat (3) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter N_TESTS, default 8, number of test channels (1..32).
REQ-002 Parameter TIMEOUT, default 1024, watchdog limit in clk cycles (>=2).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin run; sampled in IDLE or FINISH only.
REQ-006 test_mask  input  N_TESTS  tests selected for the run; captured on accepted start.
REQ-007 done  input  1  shared completion level from the active test.
REQ-008 fails  input  N_TESTS  per-test fail levels; bit i valid only while done is high with test i active.
REQ-009 en  output  N_TESTS  one-hot or zero test enables; registered.
REQ-010 busy  output  1  high in SCAN and RUN.
REQ-011 finished  output  1  high in FINISH.
REQ-012 pass  output  1  high in FINISH when fail_mask==0 and aborted==0.
REQ-013 fail_mask  output  N_TESTS  accumulated failures for the current/last run.
REQ-014 timeout_mask  output  N_TESTS  tests that hit the watchdog.
REQ-015 aborted  output  1  run stopped because done stayed high in SCAN.
REQ-016 cur_index  output  $clog2(N_TESTS) (min 1)  index of the active/next test.

Function
REQ-017 States: IDLE, SCAN, RUN, FINISH; all outputs registered.
REQ-018 IDLE/FINISH with start=1: load pending<=test_mask, clear fail_mask/timeout_mask/aborted, go SCAN; start ignored in SCAN/RUN.
REQ-019 SCAN, pending==0: go FINISH, en stays 0.
REQ-020 SCAN, pending!=0, done=0: cur_index<=lowest set pending bit, en<=onehot(that index), go RUN; en rises on the first edge after SCAN entry at the earliest.
REQ-021 SCAN, done=1: wait with en=0 (previous test has not released done).
REQ-022 RUN, done=1: fail_mask[cur_index]<=fails[cur_index], pending[cur_index]<=0, en<=0, go SCAN; other fails bits ignored.
REQ-023 Unselected tests never receive en; their fail_mask/timeout_mask bits stay 0.
REQ-024 en never has more than one bit set; en is 0 for at least one cycle between consecutive tests.
REQ-025 FINISH holds all results until start or rst; finished=1, busy=0.
REQ-026 test_mask==0 on start: SCAN one cycle, then FINISH with pass=1.

Reset
REQ-027 rst=1 at a posedge: state IDLE, en=0, busy=0, finished=0, pass=0, fail_mask=0, timeout_mask=0, aborted=0, cur_index=0, pending=0, watchdog=0.
REQ-028 rst overrides start and done in the same cycle; rst mid-RUN drops en on that edge.

Configuration
REQ-029 Macro TEST_SEQUENCER_WATCHDOG_EN compiles in the watchdog; default build leaves it undefined.
REQ-030 Defined: counter clears on entry to RUN and SCAN and increments each cycle there.
REQ-031 Defined, RUN, counter reaches TIMEOUT-1 with done=0: fail_mask[cur_index]<=1, timeout_mask[cur_index]<=1, pending bit cleared, en<=0, go SCAN; done=1 on that same cycle is a normal completion.
REQ-032 Defined, SCAN, done=1 for TIMEOUT consecutive cycles: aborted<=1, go FINISH, remaining pending tests not run, pass=0.
REQ-033 Undefined: no counter logic; RUN and SCAN wait indefinitely; timeout_mask and aborted tied 0.

Verification
REQ-034 N_TESTS=8, mask=8'hFF, every test raises done 3 cycles after en with fail=0 -> en walks bits 0..7 in order, finished=1, pass=1, fail_mask=0.
REQ-035 mask=8'b1010_0101, test 2 fails -> en only on 0,2,5,7; fail_mask=8'h04, pass=0.
REQ-036 start with done held high -> en stays 0 until done drops, then en=8'h01 one edge later.
REQ-037 Watchdog on, TIMEOUT=16, test 3 never raises done -> en[3] high exactly 16 cycles, timeout_mask=8'h08, fail_mask=8'h08, test 4 runs next.
REQ-038 Watchdog on, done stuck high after test 1 -> aborted=1 after 16 SCAN cycles, finished=1, tests 2..7 never enabled.
REQ-039 rst pulsed mid-RUN of test 4 -> next edge en=0, all outputs at reset values; new start runs from test 0.
